mmio_hex_ctrl: RTL and testbench

//  Memory-mapped display peripheral on the processor bus; successor to the single fixed LED register.

---
 rtl/mmio_hex_pkg.sv | 25 ++
 rtl/hex7seg_dec.sv | 12 +
 rtl/mmio_hex_ctrl.sv | 118 +++++++++++
 tb/tb_mmio_hex_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mmio_hex_pkg.sv
// Shared constants for the memory-mapped hex display: register offsets, CTRL bit positions, glyphs.
// Glyph bit 6 = seg a ... bit 0 = seg g, active-low.
package mmio_hex_pkg;

    localparam logic OFS_VALUE = 1'b0;
    localparam logic OFS_CTRL  = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // CTRL layout: [ndigits-1:0] blank mask, then zsup, then blink_en
    function automatic int ctrl_zsup_bit(input int ndigits);
        return ndigits;
    endfunction

    function automatic int ctrl_blink_bit(input int ndigits);
        return ndigits + 1;
    endfunction

    // Listed from index 15 (F) down to index 0 (0)
    localparam logic [15:0][6:0] GLYPH = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

endpackage

// File: rtl/hex7seg_dec.sv
// Nibble to active-low seven-segment glyph; combinational, zero latency.
// No flow control: output follows input.
module hex7seg_dec
    import mmio_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = GLYPH[nibble];

endmodule

// File: rtl/mmio_hex_ctrl.sv
// Bus-mapped VALUE/CTRL registers driving LEDs and NDIGITS hex digits with blank, zsup, blink.
// Latency: LEDs same edge as the write, HEX one edge later; rd_data 1 cycle when HEX_READBACK_EN.
// Backpressure: none, every in-window write strobe is accepted.
module mmio_hex_ctrl
    import mmio_hex_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                NDIGITS   = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h1000,
    parameter int                BLINK_DIV = 25000000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      data,
    input  logic                   W,
    output logic [DATA_W-1:0]      rd_data,
    output logic [DATA_W-1:0]      LEDs,
    output logic [7*NDIGITS-1:0]   HEX
);

    localparam int CTRL_W    = NDIGITS + 2;
    localparam int ZSUP_BIT  = ctrl_zsup_bit(NDIGITS);
    localparam int BLINK_BIT = ctrl_blink_bit(NDIGITS);
    localparam int CNT_W     = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [DATA_W-1:0]    value_q;
    logic [CTRL_W-1:0]    ctrl_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 phase_q;
    logic [7*NDIGITS-1:0] hex_d;
    logic                 in_win;
    logic                 wr_value;
    logic                 wr_ctrl;
    logic                 blink_on;
    logic                 zsup_on;

    assign in_win   = (addr[ADDR_W-1:1] == BASE_ADDR[ADDR_W-1:1]);
    assign wr_value = W && in_win && (addr[0] == OFS_VALUE);
    assign wr_ctrl  = W && in_win && (addr[0] == OFS_CTRL);
    assign blink_on = ctrl_q[BLINK_BIT];
    assign zsup_on  = ctrl_q[ZSUP_BIT];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            value_q <= '0;
            ctrl_q  <= '0;
        end else begin
            if (wr_value)
                value_q <= data;
            if (wr_ctrl)
                ctrl_q <= data[CTRL_W-1:0];
        end
    end

    // Held at 0 while blink is off, so a 0->1 enable always starts on the visible half
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!blink_on) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NDIGITS; i++) begin : g_dig
        logic [6:0] glyph;
        logic       lead_zero;
        logic       dark;

        hex7seg_dec u_dec (
            .nibble (value_q[4*i +: 4]),
            .seg    (glyph)
        );

        if (i == 0) begin : g_lsd
            assign lead_zero = 1'b0;
        end else begin : g_upper
            assign lead_zero = (value_q[DATA_W-1:4*i] == '0);
        end

        assign dark             = ctrl_q[i] || (blink_on && phase_q) || (zsup_on && lead_zero);
        assign hex_d[7*i +: 7]  = dark ? SEG_BLANK : glyph;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            HEX <= '1;
        else
            HEX <= hex_d;
    end

    assign LEDs = value_q;

`ifdef HEX_READBACK_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if (!in_win)
            rd_data <= '0;
        else if (addr[0] == OFS_CTRL)
            rd_data <= DATA_W'(ctrl_q);
        else
            rd_data <= value_q;
    end
`else
    assign rd_data = '0;
`endif

endmodule

// File: tb/tb_mmio_hex_ctrl.sv
// Directed bench for mmio_hex_ctrl with BLINK_DIV=4; inputs change on negedge, outputs checked on negedge.
module tb_mmio_hex_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] data;
    logic        W;
    logic [15:0] rd_data;
    logic [15:0] LEDs;
    logic [27:0] HEX;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [27:0] DARK = 28'hFFFFFFF;

    mmio_hex_ctrl #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .NDIGITS   (4),
        .BASE_ADDR (16'h1000),
        .BLINK_DIV (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .addr     (addr),
        .data     (data),
        .W        (W),
        .rd_data  (rd_data),
        .LEDs     (LEDs),
        .HEX      (HEX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] gl(input int n);
        case (n)
            0:  return 7'h01;
            1:  return 7'h4F;
            2:  return 7'h12;
            3:  return 7'h06;
            4:  return 7'h4C;
            5:  return 7'h24;
            6:  return 7'h20;
            7:  return 7'h0F;
            8:  return 7'h00;
            9:  return 7'h04;
            10: return 7'h08;
            11: return 7'h60;
            12: return 7'h31;
            13: return 7'h42;
            14: return 7'h30;
            default: return 7'h38;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns on the negedge following the write edge
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a;
        data = d;
        W    = 1'b1;
        @(negedge clk);
        W    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        addr  = '0;
        data  = '0;
        W     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_leds", LEDs, 16'h0);
        chk("rst_hex", HEX, DARK);
        chk("rst_rd", rd_data, 16'h0);
        reset = 1'b0;
        @(negedge clk);

        wr(16'h1000, 16'h12AF);
        chk("wr_leds", LEDs, 16'h12AF);
        @(negedge clk);
        chk("wr_hex", HEX, {gl(1), gl(2), gl(10), gl(15)});

        wr(16'h0FFF, 16'h5555);
        wr(16'h1002, 16'h003F);
        chk("oow_leds", LEDs, 16'h12AF);
        @(negedge clk);
        chk("oow_hex", HEX, {gl(1), gl(2), gl(10), gl(15)});

        wr(16'h1001, 16'h0010);
        wr(16'h1000, 16'h0005);
        @(negedge clk);
        chk("zsup_5", HEX, {BL, BL, BL, gl(5)});
        wr(16'h1000, 16'h0000);
        @(negedge clk);
        chk("zsup_0", HEX, {BL, BL, BL, gl(0)});
        wr(16'h1000, 16'h0100);
        @(negedge clk);
        chk("zsup_100", HEX, {BL, gl(1), gl(0), gl(0)});

        wr(16'h1001, 16'h0005);
        wr(16'h1000, 16'h8888);
        @(negedge clk);
        chk("blank_mask", HEX, {gl(8), BL, gl(8), BL});

        // Blink on: 4 lit, 4 dark, repeating; a rewrite at k=6 must not restart it
        wr(16'h1001, 16'h0020);
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) begin
                addr = 16'h1001;
                data = 16'h0020;
                W    = 1'b1;
            end
            @(negedge clk);
            W = 1'b0;
            chk($sformatf("blink_k%0d", k), HEX, (((k - 1) / 4) % 2 == 1) ? DARK : 28'h0);
        end
        wr(16'h1001, 16'h0000);
        @(negedge clk);
        chk("blink_off", HEX, 28'h0);

        // Async reset between edges, with a write pending
        wr(16'h1000, 16'h4321);
        @(negedge clk);
        addr = 16'h1000;
        data = 16'h9999;
        W    = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("arst_leds", LEDs, 16'h0);
        chk("arst_hex", HEX, DARK);
        chk("arst_rd", rd_data, 16'h0);
        @(negedge clk);
        W     = 1'b0;
        reset = 1'b0;
        chk("arst_write_lost", LEDs, 16'h0);
        @(negedge clk);

`ifdef HEX_READBACK_EN
        wr(16'h1000, 16'hBEEF);
        @(negedge clk);
        chk("rd_value", rd_data, 16'hBEEF);
        addr = 16'h2000;
        @(negedge clk);
        chk("rd_outside", rd_data, 16'h0);
        wr(16'h1001, 16'hFFFF);
        @(negedge clk);
        chk("rd_ctrl", rd_data, 16'h003F);
`else
        wr(16'h1000, 16'hBEEF);
        @(negedge clk);
        chk("rd_tied_value", rd_data, 16'h0);
        addr = 16'h1001;
        @(negedge clk);
        chk("rd_tied_ctrl", rd_data, 16'h0);
        chk("rd_tied_leds", LEDs, 16'hBEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
